// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory, decoder and redirect handshakes for the fetch unit.
`default_nettype none

interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_pc,
    output fetch_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_pc,
    input  fetch_err
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module  : instr_fetch
// Brief   : Single-outstanding RV64 instruction fetch unit with PC redirect.
//           Optional macro IFU_MISALIGN_CHECK_EN faults misaligned redirects.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  instr_fetch_if.master bus
);

  localparam logic [2:0] S_REQ   = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic [2:0]  r_state;
  logic [63:0] r_pc;
  logic [31:0] r_instr;
  logic [63:0] r_instr_pc;
  logic        r_fetch_err;

  logic [2:0]  w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [63:0] w_instr_pc_nxt;
  logic        w_err_nxt;
  logic [63:0] w_redir_pc;
  logic        w_misalign;

  assign w_redir_pc = {bus.redirect_pc[63:2], 2'b00};

`ifdef IFU_MISALIGN_CHECK_EN
  assign w_misalign = |bus.redirect_pc[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_err_nxt      = r_fetch_err;

    if (bus.redirect_valid) begin
      if (w_misalign) begin
        // Misaligned target: fault without issuing a request; any response
        // still in flight lands in ERR where it is ignored.
        w_state_nxt = S_ERR;
        w_err_nxt   = 1'b1;
      end else begin
        w_pc_nxt  = w_redir_pc;
        w_err_nxt = 1'b0;
        case (r_state)
          S_REQ:   w_state_nxt = S_REQ;
          S_WAIT:  w_state_nxt = bus.imem_rsp_valid ? S_REQ : S_FLUSH;
          S_HOLD:  w_state_nxt = S_REQ;
          S_FLUSH: w_state_nxt = bus.imem_rsp_valid ? S_REQ : S_FLUSH;
          S_ERR:   w_state_nxt = S_REQ;
          default: w_state_nxt = S_REQ;
        endcase
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (bus.imem_req_ready) begin
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (bus.imem_rsp_err) begin
              w_state_nxt = S_ERR;
              w_err_nxt   = 1'b1;
            end else begin
              w_state_nxt    = S_HOLD;
              w_instr_nxt    = bus.imem_rsp_data;
              w_instr_pc_nxt = r_pc;
              w_pc_nxt       = r_pc + 64'd4;
            end
          end
        end
        S_HOLD: begin
          if (bus.instr_ready) begin
            w_state_nxt = S_REQ;
          end
        end
        S_FLUSH: begin
          if (bus.imem_rsp_valid) begin
            w_state_nxt = S_REQ;
          end
        end
        S_ERR:   w_state_nxt = S_ERR;
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_instr     <= C_NOP;
      r_instr_pc  <= 64'd0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_instr     <= w_instr_nxt;
      r_instr_pc  <= w_instr_pc_nxt;
      r_fetch_err <= w_err_nxt;
    end
  end

  // Outputs decode registered state only; no input reaches an output.
  assign bus.imem_req_valid = (r_state == S_REQ);
  assign bus.imem_req_addr  = r_pc;
  assign bus.instr_valid    = (r_state == S_HOLD);
  assign bus.instr          = r_instr;
  assign bus.instr_pc       = r_instr_pc;
  assign bus.fetch_err      = r_fetch_err;

endmodule

`default_nettype wire
